uart_apb_if: RTL
================

UART_APB_IF -- requirements
Module: uart_apb_if

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the width of the APB address bus; only paddr[4:2] is decoded.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the width of the APB data bus; only bits [7:0] are used and the upper bits read as 0.
REQ-003 The block SHALL have the following ports:
  clk  in  1  system clock; one clock domain only.
  rst_n  in  1  reset; synchronous, active-low.
  psel  in  1  APB select.
  penable  in  1  APB enable.
  pwrite  in  1  APB write.
  paddr  in  ADDR_W  APB address.
  pwdata  in  DATA_W  APB write data.
  prdata  out  DATA_W  APB read data.
  pready  out  1  APB ready.
  pslverr  out  1  APB error.
  FSR_i  in  8  UART FIFO status: [3] rx_empty, [2] rx_full, [1] tx_empty, [0] tx_full.
  RBR_i  in  8  RX FIFO head data.
  TBR_o  out  8  TX write data.
  tx_flag  out  1  TX FIFO push pulse.
  rx_flag  out  1  RX FIFO pop pulse.
  OSM_SEL, BGE, PEN, EPS, STB  out  1 each  line-control bits.
  WLS  out  2  word length select.
  DLL, DLH  out  8 each  baud divisor.
  en_tx_fifo_empty, en_tx_fifo_full, en_rx_fifo_empty, en_rx_fifo_full  out  1 each  interrupt enables.

Function
REQ-004 The register map SHALL use these word offsets:
  0x00 MDR RW: [0] OSM_SEL.
  0x04 DLL RW.
  0x08 DLH RW.
  0x0C LCR RW: [1:0] WLS, [2] STB, [3] PEN, [4] EPS, [5] BGE.
  0x10 IER RW: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty enables.
  0x14 FSR RO.
  0x18 TBR WO.
  0x1C RBR RO.
REQ-005 The FSM SHALL have states IDLE, SETUP and ACCESS.
  IDLE->SETUP on psel & !penable.
  SETUP->ACCESS unconditionally.
  ACCESS->SETUP on psel & !penable; otherwise ACCESS->IDLE.
REQ-006 pready SHALL be 1 only in ACCESS, giving zero wait states.
REQ-007 Read data SHALL be registered in SETUP and held stable in ACCESS; prdata SHALL be 0 outside ACCESS.
REQ-008 RW register writes SHALL take effect at the ACCESS clock edge; unused bits SHALL be discarded and read back as 0.
REQ-009 For a TBR write with FSR_i[0]=0, TBR_o SHALL be loaded with pwdata[7:0] and tx_flag SHALL pulse exactly one cycle, in the cycle after ACCESS.
REQ-010 For a TBR write with FSR_i[0]=1, the write SHALL be dropped: no tx_flag and TBR_o unchanged.
REQ-011 For an RBR read, prdata SHALL carry RBR_i sampled in SETUP; if FSR_i[3]=0, rx_flag SHALL pulse one cycle after ACCESS; if FSR_i[3]=1, prdata SHALL be 0 and there SHALL be no pulse.
REQ-012 Reads of TBR, writes to FSR/RBR, and unmapped offsets SHALL have no side effect, and such reads SHALL return 0.
REQ-013 Back-to-back transfers (ACCESS->SETUP) SHALL each produce their own pulse, with no pulse merged or lost.
REQ-014 Deassertion of psel mid-transfer SHALL return the FSM to IDLE with no side effect.

Reset
REQ-015 On rst_n=0 at a clock edge, all registers SHALL clear to 0, the FSM SHALL enter IDLE, and tx_flag, rx_flag, pready, pslverr and prdata SHALL be 0.
REQ-016 A reset asserted during ACCESS SHALL suppress any pending pulse.

Configuration
REQ-017 With UART_APB_SLVERR_EN defined, pslverr SHALL be 1 in ACCESS for: TBR write while full, RBR read while empty, unmapped offset, write to RO, or read of WO.
REQ-018 Without UART_APB_SLVERR_EN, pslverr SHALL be tied to 0 and the behaviour in REQ-010 to REQ-012 SHALL be otherwise unchanged.

Structure
REQ-019 Package uart_pkg SHALL hold the register offset constants, the LCR/IER/FSR bit-index constants and the FSM state typedef.
REQ-020 The block SHALL be a single module with no sub-module; the address decode SHALL be inline.

Verification
REQ-021 Reset then read all offsets -> every read SHALL return 0x00000000, pslverr=0.
REQ-022 Write LCR=0x2B, DLL=0x1A, then read LCR -> WLS=3, STB=0, PEN=1, EPS=0, BGE=1, DLL=0x1A, and the read SHALL return 0x2B.
REQ-023 Write TBR=0xA5 with FSR_i=0x0A -> TBR_o=0xA5 and tx_flag high for exactly 1 cycle, the cycle after ACCESS.
REQ-024 Write TBR=0x55 with FSR_i=0x01 -> no tx_flag, TBR_o unchanged, and pslverr=1 only when UART_APB_SLVERR_EN is defined.
REQ-025 Read RBR with RBR_i=0x3C and FSR_i=0x00 -> prdata=0x3C and one rx_flag pulse; repeat with FSR_i=0x08 -> prdata=0 and no pulse.
REQ-026 Two back-to-back TBR writes 0x11 then 0x22 -> exactly two tx_flag pulses, with TBR_o=0x11 then 0x22.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART APB register interface: register word offsets,
// LCR/IER/FSR bit positions and the APB slave FSM state type.
package uart_pkg;

    localparam logic [2:0] OFF_MDR = 3'd0;
    localparam logic [2:0] OFF_DLL = 3'd1;
    localparam logic [2:0] OFF_DLH = 3'd2;
    localparam logic [2:0] OFF_LCR = 3'd3;
    localparam logic [2:0] OFF_IER = 3'd4;
    localparam logic [2:0] OFF_FSR = 3'd5;
    localparam logic [2:0] OFF_TBR = 3'd6;
    localparam logic [2:0] OFF_RBR = 3'd7;

    localparam int LCR_WLS_LO = 0;
    localparam int LCR_STB    = 2;
    localparam int LCR_PEN    = 3;
    localparam int LCR_EPS    = 4;
    localparam int LCR_BGE    = 5;

    localparam int IER_TX_FULL  = 0;
    localparam int IER_TX_EMPTY = 1;
    localparam int IER_RX_FULL  = 2;
    localparam int IER_RX_EMPTY = 3;

    localparam int FSR_TX_FULL  = 0;
    localparam int FSR_TX_EMPTY = 1;
    localparam int FSR_RX_FULL  = 2;
    localparam int FSR_RX_EMPTY = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/uart_apb_if.sv
// APB slave holding the UART control registers and the TX push / RX pop strobes.
// Optional error response: define UART_APB_SLVERR_EN to drive pslverr.
module uart_apb_if
    import uart_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic [7:0]        FSR_i,
    input  logic [7:0]        RBR_i,
    output logic [7:0]        TBR_o,
    output logic              tx_flag,
    output logic              rx_flag,
    output logic              OSM_SEL,
    output logic              BGE,
    output logic              PEN,
    output logic              EPS,
    output logic              STB,
    output logic [1:0]        WLS,
    output logic [7:0]        DLL,
    output logic [7:0]        DLH,
    output logic              en_tx_fifo_empty,
    output logic              en_tx_fifo_full,
    output logic              en_rx_fifo_empty,
    output logic              en_rx_fifo_full
);

    apb_state_t r_state;
    apb_state_t w_state_nxt;

    logic       r_osm;
    logic [7:0] r_dll;
    logic [7:0] r_dlh;
    logic [5:0] r_lcr;
    logic [3:0] r_ier;
    logic [7:0] r_tbr;
    logic       r_tx_flag;
    logic       r_rx_flag;

    logic       r_wr;
    logic [2:0] r_idx;
    logic [7:0] r_wdat;
    logic [7:0] r_rdata;
    logic       r_tx_ok;
    logic       r_rx_ok;

    logic [2:0] w_idx;
    logic [7:0] w_rd_mux;
    logic       w_commit;
    logic       w_unused;

    assign w_idx    = paddr[4:2];
    assign w_commit = (r_state == ST_ACCESS) && psel && penable;
    assign w_unused = ^{paddr[ADDR_W-1:5], paddr[1:0], pwdata[DATA_W-1:8], FSR_i[7:4]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (psel && !penable) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = (psel && !penable) ? ST_SETUP : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_idx)
            OFF_MDR: w_rd_mux = {7'd0, r_osm};
            OFF_DLL: w_rd_mux = r_dll;
            OFF_DLH: w_rd_mux = r_dlh;
            OFF_LCR: w_rd_mux = {2'd0, r_lcr};
            OFF_IER: w_rd_mux = {4'd0, r_ier};
            OFF_FSR: w_rd_mux = {4'd0, FSR_i[FSR_RX_EMPTY], FSR_i[FSR_RX_FULL],
                                 FSR_i[FSR_TX_EMPTY], FSR_i[FSR_TX_FULL]};
            OFF_RBR: w_rd_mux = FSR_i[FSR_RX_EMPTY] ? 8'h00 : RBR_i;
            default: w_rd_mux = 8'h00;
        endcase
    end

    // The transfer is captured while in SETUP and only committed at the ACCESS
    // edge if the master still holds psel/penable, so an abandoned transfer is inert.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_osm     <= 1'b0;
            r_dll     <= 8'h00;
            r_dlh     <= 8'h00;
            r_lcr     <= 6'd0;
            r_ier     <= 4'd0;
            r_tbr     <= 8'h00;
            r_tx_flag <= 1'b0;
            r_rx_flag <= 1'b0;
            r_wr      <= 1'b0;
            r_idx     <= 3'd0;
            r_wdat    <= 8'h00;
            r_rdata   <= 8'h00;
            r_tx_ok   <= 1'b0;
            r_rx_ok   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_flag <= 1'b0;
            r_rx_flag <= 1'b0;
            if (r_state == ST_SETUP) begin
                r_wr    <= pwrite;
                r_idx   <= w_idx;
                r_wdat  <= pwdata[7:0];
                r_tx_ok <= ~FSR_i[FSR_TX_FULL];
                r_rx_ok <= ~FSR_i[FSR_RX_EMPTY];
                r_rdata <= (psel && !pwrite) ? w_rd_mux : 8'h00;
            end
            if (w_commit) begin
                if (r_wr) begin
                    case (r_idx)
                        OFF_MDR: r_osm <= r_wdat[0];
                        OFF_DLL: r_dll <= r_wdat;
                        OFF_DLH: r_dlh <= r_wdat;
                        OFF_LCR: r_lcr <= r_wdat[5:0];
                        OFF_IER: r_ier <= r_wdat[3:0];
                        OFF_TBR: begin
                            if (r_tx_ok) begin
                                r_tbr     <= r_wdat;
                                r_tx_flag <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if ((r_idx == OFF_RBR) && r_rx_ok) begin
                    r_rx_flag <= 1'b1;
                end
            end
        end
    end

`ifdef UART_APB_SLVERR_EN
    logic r_err;
    logic w_err;

    always_comb begin
        w_err = 1'b0;
        if (pwrite)
            w_err = ((w_idx == OFF_TBR) && FSR_i[FSR_TX_FULL]) ||
                    (w_idx == OFF_FSR) || (w_idx == OFF_RBR);
        else
            w_err = (w_idx == OFF_TBR) || ((w_idx == OFF_RBR) && FSR_i[FSR_RX_EMPTY]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (r_state == ST_SETUP)
            r_err <= psel && w_err;
    end

    assign pslverr = (r_state == ST_ACCESS) && r_err;
`else
    assign pslverr = 1'b0;
`endif

    assign pready  = (r_state == ST_ACCESS);
    assign prdata  = (r_state == ST_ACCESS) ? DATA_W'(r_rdata) : '0;

    assign TBR_o   = r_tbr;
    assign tx_flag = r_tx_flag;
    assign rx_flag = r_rx_flag;

    assign OSM_SEL = r_osm;
    assign DLL     = r_dll;
    assign DLH     = r_dlh;
    assign WLS     = r_lcr[LCR_WLS_LO +: 2];
    assign STB     = r_lcr[LCR_STB];
    assign PEN     = r_lcr[LCR_PEN];
    assign EPS     = r_lcr[LCR_EPS];
    assign BGE     = r_lcr[LCR_BGE];

    assign en_tx_fifo_full  = r_ier[IER_TX_FULL];
    assign en_tx_fifo_empty = r_ier[IER_TX_EMPTY];
    assign en_rx_fifo_full  = r_ier[IER_RX_FULL];
    assign en_rx_fifo_empty = r_ier[IER_RX_EMPTY];

endmodule
